shield_read_verifier: RTL and testbench
=======================================

# shield_read_verifier

Consumer stage behind `shield_read_decryptor` on the shield read path. Buffers ciphertext lines and their stored HMAC tags arriving from memory, pairs each in order with the keystream pad and computed tag the decryptor produces, and emits plaintext. It flags per-line authentication failures and keeps a sticky failure flag and a saturating failure counter for the shield controller.

## Interface
Parameters:
- `SHIELD_ADDR_WIDTH`, 32, line address width
- `LINE_WIDTH`, 512, line width in bits
- `HMAC_TAG_WIDTH`, 128, tag width compared
- `CT_FIFO_DEPTH`, 4, ciphertext buffer entries; power of two, ≥2
- `ERR_CNT_WIDTH`, 16, failure counter width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ct_data`  in  LINE_WIDTH  ciphertext line from memory
- `ct_tag`  in  HMAC_TAG_WIDTH  tag stored in memory for the line
- `ct_addr`  in  SHIELD_ADDR_WIDTH  line address
- `ct_val` / `ct_rdy`  in / out  1  ciphertext handshake
- `pad`  in  LINE_WIDTH  keystream pad from the decryptor
- `calc_tag`  in  HMAC_TAG_WIDTH  tag computed by the decryptor
- `pad_val` / `pad_rdy`  in / out  1  decryptor response handshake
- `out_data`  out  LINE_WIDTH  plaintext
- `out_addr`  out  SHIELD_ADDR_WIDTH  line address
- `out_auth_fail`  out  1  tag mismatch for this line
- `out_val` / `out_rdy`  out / in  1  output handshake
- `err_clr`  in  1  clears the sticky flag and the counter
- `auth_fail_sticky`  out  1  set on any failure
- `auth_fail_count`  out  ERR_CNT_WIDTH  saturating failure count

## Operation
- A transfer occurs when val and rdy are both high on a rising edge. Once val is asserted, the sender holds it and its data stable until the transfer.
- Ciphertext FIFO: entry is {ct_data, ct_tag, ct_addr}. Write and read pointers wrap modulo `CT_FIFO_DEPTH`. Occupancy count is `$clog2(CT_FIFO_DEPTH)+1` bits. `ct_rdy = (count != CT_FIFO_DEPTH)`.
- No fall-through: an entry written in cycle N is poppable from cycle N+1.
- Full with a simultaneous pop: `ct_rdy` stays low that cycle. No push is accepted.
- Output register has two states, EMPTY and FULL.
  - `pad_rdy` is high when the FIFO is non-empty and the register is EMPTY, or when it is FULL with `out_rdy` high.
  - On a pad transfer: pop the head entry, load `out_data = ct_data ^ pad`, `out_addr = ct_addr`, `out_auth_fail = (calc_tag != ct_tag)`, and go to FULL.
  - FULL with `out_rdy` and no pad transfer: go to EMPTY.
- Pairing is strictly in order. A pad that arrives while the FIFO is empty waits with `pad_rdy` low.
- Failure tracking happens on each pad transfer with a mismatch:
  - the sticky flag is set to 1;
  - the counter increments and saturates at all-ones.
- Simultaneous `err_clr` and a new failure: the clear applies first, giving a flag of 1 and a count of 1.
- `err_clr` with no failure: flag 0, count 0.
- Reset mid-operation: FIFO contents, pointers, output register, flag and counter are discarded or cleared. In-flight lines are lost, and the upstream owner re-issues them.

## Timing
- Reset values:
  - `out_val` 0, `out_auth_fail` 0, `out_data`/`out_addr` 0
  - `pad_rdy` 0, `ct_rdy` 1
  - `auth_fail_sticky` 0, `auth_fail_count` 0
- Latency:
  - ct transfer to `pad_rdy` is possible: 1 cycle.
  - pad transfer to `out_val`: 1 cycle, registered.
- Throughput is 1 line/cycle when `out_rdy` stays high and both inputs stream.
- `out_*` hold stable while `out_val && !out_rdy`.
- `auth_fail_sticky` and `auth_fail_count` update on the same edge that loads the failing line.

## Configuration
- `SHIELD_AUTH_POISON_EN`
  - Defined: a failing line is output with `out_data` forced to all zeros, so plaintext is never released from an unauthenticated line. `out_auth_fail` is still 1.
  - Undefined: `out_data` is always `ct_data ^ pad`.
- Handshakes, flag and counter are identical in both builds.

## Structure
- `shield_pkg` holds:
  - the `shield_ct_entry_t` struct typedef (data, tag, addr);
  - the `SHIELD_ERR_CNT_MAX` constant.
- Sub-module `shield_sync_fifo` (parameterised width and depth, async active-high reset) implements the ciphertext buffer. The output register and failure logic live in the top.

## Test plan
- Single line: ct_data=512'hA5..A5, pad=512'h5A..5A, tags equal → one cycle after the pad transfer, out_data=all ones, out_auth_fail=0, sticky=0.
- Tag mismatch: ct_tag=128'h1, calc_tag=128'h2 → out_auth_fail=1, sticky=1, count=1. Repeat with the counter preloaded to 16'hFFFE twice → count saturates at 16'hFFFF.
- Fill FIFO with 4 lines, no pads → ct_rdy=0 on the fifth. Pads with out_rdy=1 → lines emerge in address order 0x0,0x40,0x80,0xC0.
- Backpressure: out_rdy=0 for 5 cycles with pad_val=1 → out_val held, out_data stable, pad_rdy=0. Release → back-to-back outputs at 1/cycle.
- err_clr in the same cycle as a failing pad transfer → sticky=1, count=1. err_clr alone next cycle → 0, 0.
- Assert rst with 3 lines buffered and out_val=1 → out_val=0 immediately, ct_rdy=1, count=0. Subsequent lines pair correctly.

Source files
------------

// File: rtl/shield_pkg.sv
// shield_pkg
//   Shared types and constants for the shield read path.
//   - shield_ct_entry_t : one buffered ciphertext line {data, tag, addr}. Its
//     field widths fix the line geometry; instantiate shield_read_verifier with
//     LINE_WIDTH / HMAC_TAG_WIDTH / SHIELD_ADDR_WIDTH equal to the SHIELD_*_W
//     values below.
//   - out_state_e       : output register occupancy.
//   - SHIELD_ERR_CNT_MAX: saturation ceiling for the failure counter. It is
//     all-ones and is truncated to the counter width at the point of use.
package shield_pkg;

    localparam int SHIELD_ADDR_W = 32;
    localparam int SHIELD_LINE_W = 512;
    localparam int SHIELD_TAG_W  = 128;

    typedef struct packed {
        logic [SHIELD_LINE_W-1:0] data;
        logic [SHIELD_TAG_W-1:0]  tag;
        logic [SHIELD_ADDR_W-1:0] addr;
    } shield_ct_entry_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    localparam logic [63:0] SHIELD_ERR_CNT_MAX = '1;

endpackage

// File: rtl/shield_sync_fifo.sv
// shield_sync_fifo
//   Synchronous FIFO, no fall-through: a word written on edge N is visible at
//   rd_data from edge N onward (i.e. poppable in cycle N+1). Pointers wrap
//   modulo DEPTH (power of two, >= 2).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_data      push; caller only asserts wr_en when !full
//   rd_en, rd_data      pop of the head word; caller only asserts when !empty
//   full, empty         occupancy flags
module shield_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset: stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (rd_en && !wr_en) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/shield_read_verifier.sv
// shield_read_verifier
//   Pairs buffered ciphertext lines (with their stored tags) in order with the
//   keystream pad and computed tag from the decryptor, emits plaintext through
//   a single output register, and tracks authentication failures.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   ct_data/ct_tag/ct_addr, ct_val/ct_rdy   ciphertext line in
//   pad/calc_tag, pad_val/pad_rdy     decryptor response in
//   out_data/out_addr/out_auth_fail, out_val/out_rdy   plaintext out
//   err_clr                           clears sticky flag and counter
//   auth_fail_sticky, auth_fail_count failure status (counter saturates)
// Build option:
//   SHIELD_AUTH_POISON_EN  when defined, a failing line is released with
//                          out_data forced to zero.
module shield_read_verifier
    import shield_pkg::*;
#(
    parameter int SHIELD_ADDR_WIDTH = SHIELD_ADDR_W,
    parameter int LINE_WIDTH        = SHIELD_LINE_W,
    parameter int HMAC_TAG_WIDTH    = SHIELD_TAG_W,
    parameter int CT_FIFO_DEPTH     = 4,
    parameter int ERR_CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LINE_WIDTH-1:0]        ct_data,
    input  logic [HMAC_TAG_WIDTH-1:0]    ct_tag,
    input  logic [SHIELD_ADDR_WIDTH-1:0] ct_addr,
    input  logic                         ct_val,
    output logic                         ct_rdy,
    input  logic [LINE_WIDTH-1:0]        pad,
    input  logic [HMAC_TAG_WIDTH-1:0]    calc_tag,
    input  logic                         pad_val,
    output logic                         pad_rdy,
    output logic [LINE_WIDTH-1:0]        out_data,
    output logic [SHIELD_ADDR_WIDTH-1:0] out_addr,
    output logic                         out_auth_fail,
    output logic                         out_val,
    input  logic                         out_rdy,
    input  logic                         err_clr,
    output logic                         auth_fail_sticky,
    output logic [ERR_CNT_WIDTH-1:0]     auth_fail_count
);

    localparam int ENTRY_W = $bits(shield_ct_entry_t);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = SHIELD_ERR_CNT_MAX[ERR_CNT_WIDTH-1:0];

    shield_ct_entry_t      wr_entry, head;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_full, fifo_empty;
    logic                  ct_push, pad_xfer, tag_mismatch, line_fail;
    logic [LINE_WIDTH-1:0] line_data;

    out_state_e state, state_nxt;

    logic                     sticky_nxt;
    logic [ERR_CNT_WIDTH-1:0] cnt_base, cnt_nxt;

    // ---------------- ciphertext buffer ----------------
    assign wr_entry.data = ct_data;
    assign wr_entry.tag  = ct_tag;
    assign wr_entry.addr = ct_addr;

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign ct_rdy  = !fifo_full;
    assign ct_push = ct_val && ct_rdy;

    shield_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CT_FIFO_DEPTH)
    ) u_ct_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ct_push),
        .wr_data (wr_entry),
        .rd_en   (pad_xfer),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head = shield_ct_entry_t'(fifo_rd_data);

    // ---------------- pairing / output register ----------------
    // A pad is accepted only when a line is waiting and the output slot is
    // free now or is being drained this cycle.
    assign pad_rdy      = !fifo_empty && ((state == OUT_EMPTY) || out_rdy);
    assign pad_xfer     = pad_val && pad_rdy;
    assign tag_mismatch = (calc_tag != head.tag);
    assign line_fail    = pad_xfer && tag_mismatch;

`ifdef SHIELD_AUTH_POISON_EN
    assign line_data = tag_mismatch ? '0 : (head.data ^ pad);
`else
    assign line_data = head.data ^ pad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OUT_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pad_xfer)                         state_nxt = OUT_FULL;
        else if (state == OUT_FULL && out_rdy) state_nxt = OUT_EMPTY;
    end

    assign out_val = (state == OUT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data      <= '0;
            out_addr      <= '0;
            out_auth_fail <= 1'b0;
        end else if (pad_xfer) begin
            out_data      <= line_data;
            out_addr      <= head.addr;
            out_auth_fail <= tag_mismatch;
        end
    end

    // ---------------- failure tracking ----------------
    // err_clr takes effect before a same-cycle failure is counted, so the
    // pair leaves flag=1, count=1.
    always_comb begin
        cnt_base   = err_clr ? '0 : auth_fail_count;
        sticky_nxt = err_clr ? 1'b0 : auth_fail_sticky;
        cnt_nxt    = cnt_base;
        if (line_fail) begin
            sticky_nxt = 1'b1;
            if (cnt_base != CNT_MAX) cnt_nxt = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auth_fail_sticky <= 1'b0;
            auth_fail_count  <= '0;
        end else begin
            auth_fail_sticky <= sticky_nxt;
            auth_fail_count  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_shield_read_verifier.sv
module tb_shield_read_verifier;

    localparam int AW = 32, LW = 512, TW = 128, DEPTH = 4, CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0, rst = 1'b1;
    logic [LW-1:0] ct_data = '0, pad = '0, out_data;
    logic [TW-1:0] ct_tag = '0, calc_tag = '0;
    logic [AW-1:0] ct_addr = '0, out_addr;
    logic ct_val = 1'b0, ct_rdy, pad_val = 1'b0, pad_rdy;
    logic out_auth_fail, out_val, out_rdy = 1'b1, err_clr = 1'b0;
    logic auth_fail_sticky;
    logic [CW-1:0] auth_fail_count;

    shield_read_verifier #(
        .SHIELD_ADDR_WIDTH(AW), .LINE_WIDTH(LW), .HMAC_TAG_WIDTH(TW),
        .CT_FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ct_data(ct_data), .ct_tag(ct_tag), .ct_addr(ct_addr),
        .ct_val(ct_val), .ct_rdy(ct_rdy),
        .pad(pad), .calc_tag(calc_tag), .pad_val(pad_val), .pad_rdy(pad_rdy),
        .out_data(out_data), .out_addr(out_addr), .out_auth_fail(out_auth_fail),
        .out_val(out_val), .out_rdy(out_rdy),
        .err_clr(err_clr),
        .auth_fail_sticky(auth_fail_sticky), .auth_fail_count(auth_fail_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [LW-1:0] d; logic [TW-1:0] t; logic [AW-1:0] a; } line_t;
    typedef struct { logic [LW-1:0] d; logic [AW-1:0] a; logic f; } exp_t;
    line_t ct_q[$];   // lines accepted, not yet paired
    exp_t  exp_q[$];  // line expected in the output register
    logic          m_flag = 1'b0;
    logic [CW-1:0] m_cnt  = '0;

    // Everything is settled at the falling edge: check, then apply the
    // transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            ct_q.delete(); exp_q.delete();
            m_flag = 1'b0; m_cnt = '0;
            chk("rst_out_val", out_val, 0);
            chk("rst_ct_rdy", ct_rdy, 1);
            chk("rst_pad_rdy", pad_rdy, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_addr", out_addr, 0);
            chk("rst_fail", out_auth_fail, 0);
            chk("rst_sticky", auth_fail_sticky, 0);
            chk("rst_count", auth_fail_count, 0);
        end else begin
            bit ct_x, pad_x, out_x, f;
            chk("out_val", out_val, exp_q.size() != 0);
            if (exp_q.size() != 0 && out_val) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_addr", out_addr, exp_q[0].a);
                chk("out_auth_fail", out_auth_fail, exp_q[0].f);
            end
            chk("ct_rdy", ct_rdy, ct_q.size() != DEPTH);
            chk("pad_rdy", pad_rdy, ct_q.size() != 0 && (exp_q.size() == 0 || out_rdy));
            chk("sticky", auth_fail_sticky, m_flag);
            chk("count", auth_fail_count, m_cnt);

            ct_x  = ct_val && ct_rdy;
            pad_x = pad_val && pad_rdy;
            out_x = out_val && out_rdy;
            f = 1'b0;
            if (out_x && exp_q.size() != 0) void'(exp_q.pop_front());
            if (pad_x) begin
                if (ct_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pad_without_line: pad accepted with no buffered line");
                end else begin
                    line_t l;
                    exp_t  e;
                    l = ct_q.pop_front();
                    f = (calc_tag != l.t);
                    e.d = l.d ^ pad;
`ifdef SHIELD_AUTH_POISON_EN
                    if (f) e.d = '0;
`endif
                    e.a = l.a; e.f = f;
                    exp_q.push_back(e);
                end
            end
            if (err_clr) begin m_flag = 1'b0; m_cnt = '0; end
            if (f) begin
                m_flag = 1'b1;
                if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
            end
            if (ct_x) ct_q.push_back('{ct_data, ct_tag, ct_addr});
        end
    end

    // ---------------- drivers (called at posedge + #1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_ct(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [TW-1:0] t);
        bit hs;
        ct_val = 1'b1; ct_addr = a; ct_data = d; ct_tag = t;
        for (int c = 0; ; c++) begin
            @(negedge clk); hs = ct_rdy;
            step();
            if (hs) break;
            if (c > 300) begin
                n_cmp++; n_fail++;
                $display("FAIL ct_timeout: ct_rdy never high for addr %0h", a);
                break;
            end
        end
        ct_val = 1'b0;
    endtask

    task automatic send_pad(input logic [LW-1:0] p, input logic [TW-1:0] t);
        bit hs;
        pad_val = 1'b1; pad = p; calc_tag = t;
        for (int c = 0; ; c++) begin
            @(negedge clk); hs = pad_rdy;
            step();
            if (hs) break;
            if (c > 300) begin
                n_cmp++; n_fail++;
                $display("FAIL pad_timeout: pad_rdy never high");
                break;
            end
        end
        pad_val = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [TW-1:0] rnd_tag();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        for (int c = 0; c < 200 && (exp_q.size() != 0 || ct_q.size() != 0); c++) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d outputs never delivered", exp_q.size());
        end
    endtask

    localparam int NR = 60;
    logic [LW-1:0] r_d [NR];
    logic [LW-1:0] r_p [NR];
    logic [TW-1:0] r_t [NR];
    logic [TW-1:0] r_ct[NR];
    bit rnd_done = 1'b0;

    initial begin
        logic [LW-1:0] a5, x5a, d1, p1;
        a5  = {64{8'hA5}};
        x5a = {64{8'h5A}};

        // reset
        repeat (3) step();
        rst = 1'b0;
        step();

        // single line, tags equal
        send_ct(32'h0, a5, 128'h77);
        send_pad(x5a, 128'h77);
        @(negedge clk);
        chk("single_data", out_data, {LW{1'b1}});
        chk("single_fail", out_auth_fail, 0);
        chk("single_sticky", auth_fail_sticky, 0);
        step();

        // tag mismatch
        send_ct(32'h40, a5, 128'h1);
        send_pad(x5a, 128'h2);
        @(negedge clk);
        chk("mm_fail", out_auth_fail, 1);
        chk("mm_sticky", auth_fail_sticky, 1);
        chk("mm_count", auth_fail_count, 1);
        step();

        // fill FIFO, fifth line refused until a pad drains one
        fork
            begin
                for (int i = 0; i < 5; i++) send_ct(32'(i * 64), rnd_line(), 128'(i));
            end
            begin
                repeat (6) step();
                @(negedge clk);
                chk("full_ct_rdy", ct_rdy, 0);
                step();
                for (int i = 0; i < 5; i++) send_pad(rnd_line(), 128'(i));
            end
        join
        drain();

        // backpressure
        out_rdy = 1'b0;
        d1 = rnd_line(); p1 = rnd_line();
        send_ct(32'h100, d1, 128'h5);
        send_ct(32'h140, rnd_line(), 128'h6);
        send_ct(32'h180, rnd_line(), 128'h7);
        send_pad(p1, 128'h5);
        fork
            send_pad(rnd_line(), 128'h6);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_pad_rdy", pad_rdy, 0);
                    chk("bp_out_val", out_val, 1);
                    chk("bp_hold", out_data, d1 ^ p1);
                end
                step();
                out_rdy = 1'b1;
            end
        join
        send_pad(rnd_line(), 128'h7);
        drain();

        // counter saturation (counter is CW bits wide here)
        for (int i = 0; i < int'(CMAX) + 3; i++) begin
            send_ct(32'h200 + 32'(i * 64), rnd_line(), 128'h1);
            send_pad(rnd_line(), 128'h2);
        end
        @(negedge clk);
        chk("sat_count", auth_fail_count, CMAX);
        step();
        drain();

        // err_clr coincident with a failing pad transfer, then alone
        send_ct(32'h800, rnd_line(), 128'h1);
        err_clr = 1'b1;
        send_pad(rnd_line(), 128'h3);
        @(negedge clk);
        chk("clr_fail_sticky", auth_fail_sticky, 1);
        chk("clr_fail_count", auth_fail_count, 1);
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_sticky", auth_fail_sticky, 0);
        chk("clr_count", auth_fail_count, 0);
        step();
        drain();

        // reset with 3 lines buffered and a failing line in the output
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_ct(32'h900 + 32'(i * 64), rnd_line(), 128'h9);
        send_pad(rnd_line(), 128'h8);
        step();
        rst = 1'b1;
        #1;
        chk("arst_out_val", out_val, 0);
        chk("arst_ct_rdy", ct_rdy, 1);
        chk("arst_count", auth_fail_count, 0);
        step(); step();
        rst = 1'b0;
        out_rdy = 1'b1;
        step();
        d1 = rnd_line(); p1 = rnd_line();
        send_ct(32'hA00, d1, 128'hB);
        send_pad(p1, 128'hB);
        @(negedge clk);
        chk("post_rst_data", out_data, d1 ^ p1);
        chk("post_rst_addr", out_addr, 32'hA00);
        step();
        drain();

        // randomized streaming
        for (int i = 0; i < NR; i++) begin
            r_d[i] = rnd_line(); r_p[i] = rnd_line(); r_t[i] = rnd_tag();
            r_ct[i] = ($urandom_range(0, 9) < 7) ? r_t[i] : rnd_tag();
        end
        fork
            begin
                fork
                    for (int i = 0; i < NR; i++) begin
                        repeat ($urandom_range(0, 2)) step();
                        send_ct(32'h10000 + 32'(i * 64), r_d[i], r_t[i]);
                    end
                    for (int i = 0; i < NR; i++) begin
                        repeat ($urandom_range(0, 2)) step();
                        if ($urandom_range(0, 7) == 0) err_clr = 1'b1;
                        send_pad(r_p[i], r_ct[i]);
                        err_clr = 1'b0;
                    end
                join
                rnd_done = 1'b1;
            end
            for (int g = 0; g < 5000 && !rnd_done; g++) begin
                step();
                out_rdy = ($urandom_range(0, 3) != 0);
            end
        join
        out_rdy = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
